// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Shares one IO bus port (dev_id + Decoupled din/dout) between two
//   requesters. Requester 0 is the CPU core and requester 1 is the DMA/debug
//   master. Each grant covers exactly one transaction, and grants alternate
//   round-robin. A watchdog aborts a granted transaction that never
//   handshakes. The aborted requester then receives a bus-error response.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_dev_id_n                requester n device id
//   if_din_n_{valid,ready,bits}   requester n OUT data (arbiter receives)
//   if_dout_n_{valid,ready,bits}  requester n IN data (arbiter sends)
//   o_dev_id                  device id towards the IO bus decoder
//   if_bus_din_*              OUT data towards the IO bus (arbiter sends)
//   if_bus_dout_*             IN data from the IO bus (arbiter receives)
//   o_err                     one-cycle pulse in the abort cycle
//   o_err_id                  requester index of the most recent abort

// Requester-side view of the shared bus. While the requester is not
// selected, every output it sees is zero.
module io_bus_arb_req #(
  parameter logic [31:0] ErrorData = 32'hFFFF_FFFF
) (
  input  logic        sel_i,            // this requester owns the bus this cycle
  input  logic        abort_i,          // watchdog abort cycle
  input  logic        din_valid_i,
  input  logic        dout_ready_i,
  input  logic        bus_din_ready_i,
  input  logic        bus_dout_valid_i,
  input  logic [31:0] bus_dout_bits_i,
  output logic        req_o,
  output logic        din_ready_o,
  output logic        dout_valid_o,
  output logic [31:0] dout_bits_o
);
  assign req_o = din_valid_i | dout_ready_i;

  // On abort the requester's own handshake is completed locally. An OUT
  // transfer is accepted and dropped. An IN transfer returns ErrorData.
  always_comb begin
    din_ready_o  = 1'b0;
    dout_valid_o = 1'b0;
    dout_bits_o  = '0;
    if (sel_i) begin
      if (abort_i) begin
        din_ready_o  = din_valid_i;
        dout_valid_o = dout_ready_i;
        dout_bits_o  = ErrorData;
      end else begin
        din_ready_o  = bus_din_ready_i;
        dout_valid_o = bus_dout_valid_i;
        dout_bits_o  = bus_dout_bits_i;
      end
    end
  end
endmodule

module io_bus_arbiter #(
  parameter int unsigned TimeoutCycles = 1024,
  parameter logic [31:0] ErrorData     = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // requester 0
  input  logic [31:0] i_dev_id_0,
  input  logic        if_din_0_valid,
  output logic        if_din_0_ready,
  input  logic [31:0] if_din_0_bits,
  output logic        if_dout_0_valid,
  input  logic        if_dout_0_ready,
  output logic [31:0] if_dout_0_bits,
  // requester 1
  input  logic [31:0] i_dev_id_1,
  input  logic        if_din_1_valid,
  output logic        if_din_1_ready,
  input  logic [31:0] if_din_1_bits,
  output logic        if_dout_1_valid,
  input  logic        if_dout_1_ready,
  output logic [31:0] if_dout_1_bits,
  // IO bus
  output logic [31:0] o_dev_id,
  output logic        if_bus_din_valid,
  input  logic        if_bus_din_ready,
  output logic [31:0] if_bus_din_bits,
  input  logic        if_bus_dout_valid,
  output logic        if_bus_dout_ready,
  input  logic [31:0] if_bus_dout_bits,
  output logic        o_err,
  output logic        o_err_id
);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {S_IDLE, S_GRANT0, S_GRANT1} state_e;

  state_e      state_q;
  logic        last_q;
  logic [31:0] wdog_q;
  logic        err_id_q;

  logic [NUM_REQ-1:0][31:0] dev_id, din_bits, dout_bits;
  logic [NUM_REQ-1:0]       din_valid, din_ready, dout_valid, dout_ready, req;

  assign dev_id     = {i_dev_id_1, i_dev_id_0};
  assign din_bits   = {if_din_1_bits, if_din_0_bits};
  assign din_valid  = {if_din_1_valid, if_din_0_valid};
  assign dout_ready = {if_dout_1_ready, if_dout_0_ready};

  assign if_din_0_ready  = din_ready[0];
  assign if_din_1_ready  = din_ready[1];
  assign if_dout_0_valid = dout_valid[0];
  assign if_dout_1_valid = dout_valid[1];
  assign if_dout_0_bits  = dout_bits[0];
  assign if_dout_1_bits  = dout_bits[1];

  // Gating with i_rst means no handshake can complete in a reset cycle, even
  // while state_q still reports a grant.
  logic active, gidx, wd_hit, abort, fwd, done, pick;

  assign active = !i_rst && (state_q != S_IDLE);
  assign gidx   = (state_q == S_GRANT1);
  assign wd_hit = (TimeoutCycles != 0) && (wdog_q == TimeoutCycles);
  assign abort  = active && wd_hit;
  assign fwd    = active && !wd_hit;

  always_comb begin
    o_dev_id          = '0;
    if_bus_din_valid  = 1'b0;
    if_bus_din_bits   = '0;
    if_bus_dout_ready = 1'b0;
    if (fwd) begin
      o_dev_id          = dev_id[gidx];
      if_bus_din_valid  = din_valid[gidx];
      if_bus_din_bits   = din_bits[gidx];
      if_bus_dout_ready = dout_ready[gidx];
    end
  end

  // The bus-side handshakes are already forced low during abort, so done
  // cannot fire in the same cycle as an abort.
  assign done = (if_bus_din_valid & if_bus_din_ready) |
                (if_bus_dout_ready & if_bus_dout_valid);

  assign o_err    = abort;
  assign o_err_id = err_id_q;

  // Round-robin: if both requesters ask, grant the one not served last.
  assign pick = (req[0] & req[1]) ? ~last_q : req[1];

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_req
    io_bus_arb_req #(.ErrorData(ErrorData)) u_req (
      .sel_i           (active && (gidx == 1'(n))),
      .abort_i         (abort),
      .din_valid_i     (din_valid[n]),
      .dout_ready_i    (dout_ready[n]),
      .bus_din_ready_i (if_bus_din_ready),
      .bus_dout_valid_i(if_bus_dout_valid),
      .bus_dout_bits_i (if_bus_dout_bits),
      .req_o           (req[n]),
      .din_ready_o     (din_ready[n]),
      .dout_valid_o    (dout_valid[n]),
      .dout_bits_o     (dout_bits[n])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      wdog_q   <= '0;
      err_id_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            state_q <= pick ? S_GRANT1 : S_GRANT0;
            last_q  <= pick;
            wdog_q  <= '0;
          end
        end
        S_GRANT0, S_GRANT1: begin
          if (abort) begin
            state_q  <= S_IDLE;
            err_id_q <= gidx;
          end else if (done || !req[gidx]) begin
            state_q <= S_IDLE;
          end else if (wdog_q != '1) begin
            wdog_q <= wdog_q + 32'd1;   // saturate, never wrap
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
